// File: rtl/jp_pkg.sv
// Shared definitions for the NES joypad emulator.
//   BTN_*    : bit positions of each button in the 8-bit button word
//   JP_BITS  : number of serial bits per frame
//   clog2()  : ceiling log2, used to size the turbo frame counter
package jp_pkg;

    localparam int JP_BITS   = 8;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/jp_sync_edge.sv
// Synchronizer plus edge detector for one asynchronous console strobe.
//   clk   : system clock
//   rst   : synchronous active-high reset
//   din   : asynchronous input pin
//   level : synchronized level, delayed one extra flop (aligned with rise/fall)
//   rise  : one-cycle pulse when the synchronized level goes 0->1
//   fall  : one-cycle pulse when the synchronized level goes 1->0
module jp_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    logic              rise_q;
    logic              fall_q;

    // prev_q holds the previous synchronized value; the edge pulses are
    // registered alongside it so level, rise and fall all change together.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            prev_q <= sync_q[STAGES-1];
            rise_q <= sync_q[STAGES-1] & ~prev_q;
            fall_q <= ~sync_q[STAGES-1] & prev_q;
        end
    end

    assign level = prev_q;
    assign rise  = rise_q;
    assign fall  = fall_q;

endmodule

// File: rtl/jp_pad_emu.sv
// Controller-side NES joypad (4021-style parallel-in/serial-out) emulator.
//   clk_in          : system clock
//   rst_in          : synchronous active-high reset
//   buttons_in      : button states, pressed=1 (A,B,Select,Start,Up,Down,Left,Right)
//   turbo_en_in     : bit0 turbo on A, bit1 turbo on B
//   pad_latch_in    : console latch strobe, asynchronous
//   pad_clk_in      : console shift clock, asynchronous, shifts on rising edge
//   pad_data_out    : registered serial data, active-low
//   bit_cnt_out     : bits shifted since last load, saturating at 8
//   frame_out       : one-cycle pulse per latch falling edge
//   turbo_phase_out : current turbo phase
module jp_pad_emu
    import jp_pkg::*;
#(
    parameter int TURBO_FRAMES = 4,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic [7:0] buttons_in,
    input  logic [1:0] turbo_en_in,
    input  logic       pad_latch_in,
    input  logic       pad_clk_in,
    output logic       pad_data_out,
    output logic [3:0] bit_cnt_out,
    output logic       frame_out,
    output logic       turbo_phase_out
);

    localparam int FCW = (clog2(TURBO_FRAMES) > 0) ? clog2(TURBO_FRAMES) : 1;

    logic latch_lvl, latch_rise, latch_fall;
    logic clk_lvl, clk_rise, clk_fall;
    logic unused_edges;

    jp_sync_edge #(.STAGES(SYNC_STAGES)) u_latch_sync (
        .clk   (clk_in),
        .rst   (rst_in),
        .din   (pad_latch_in),
        .level (latch_lvl),
        .rise  (latch_rise),
        .fall  (latch_fall)
    );

    jp_sync_edge #(.STAGES(SYNC_STAGES)) u_clk_sync (
        .clk   (clk_in),
        .rst   (rst_in),
        .din   (pad_clk_in),
        .level (clk_lvl),
        .rise  (clk_rise),
        .fall  (clk_fall)
    );

    assign unused_edges = latch_rise ^ clk_lvl ^ clk_fall;

    logic [JP_BITS-1:0] sr, sr_next, eff;
    logic [3:0]         bit_cnt, cnt_next;
    logic [FCW-1:0]     frame_cnt;
    logic               turbo_phase;
    logic               data_q;

    // Turbo masks A/B during phase 0; the mask is sampled only at load time.
    always_comb begin
        eff        = buttons_in;
        eff[BTN_A] = buttons_in[BTN_A] & (~turbo_en_in[0] | turbo_phase);
        eff[BTN_B] = buttons_in[BTN_B] & (~turbo_en_in[1] | turbo_phase);
    end

    // Latch level has priority, so a shift edge coinciding with latch is dropped.
    always_comb begin
        sr_next  = sr;
        cnt_next = bit_cnt;
        if (latch_lvl) begin
            sr_next  = eff;
            cnt_next = 4'd0;
        end else if (clk_rise) begin
            sr_next = {1'b1, sr[JP_BITS-1:1]};
            if (bit_cnt != 4'(JP_BITS)) begin
                cnt_next = bit_cnt + 4'd1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sr          <= '0;
            bit_cnt     <= 4'd0;
            data_q      <= 1'b1;
            frame_cnt   <= '0;
            turbo_phase <= 1'b0;
        end else begin
            sr      <= sr_next;
            bit_cnt <= cnt_next;
            data_q  <= ~sr_next[0];
            if (latch_fall) begin
                if (frame_cnt == FCW'(TURBO_FRAMES - 1)) begin
                    frame_cnt   <= '0;
                    turbo_phase <= ~turbo_phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

    assign pad_data_out    = data_q;
    assign bit_cnt_out     = bit_cnt;
    assign frame_out       = latch_fall;
    assign turbo_phase_out = turbo_phase;

endmodule

// File: tb/tb_jp_pad_emu.sv
// Scoreboard bench for jp_pad_emu: stimulus pushes expected responses,
// a monitor pops them on frame pulses, bit-count increments and probes.
module tb_jp_pad_emu;

    localparam int TF = 4;
    localparam int SS = 2;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic [7:0] buttons_in = 8'h00;
    logic [1:0] turbo_en_in = 2'b00;
    logic       pad_latch_in = 1'b0;
    logic       pad_clk_in = 1'b0;
    logic       pad_data_out;
    logic [3:0] bit_cnt_out;
    logic       frame_out;
    logic       turbo_phase_out;

    jp_pad_emu #(.TURBO_FRAMES(TF), .SYNC_STAGES(SS)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .buttons_in      (buttons_in),
        .turbo_en_in     (turbo_en_in),
        .pad_latch_in    (pad_latch_in),
        .pad_clk_in      (pad_clk_in),
        .pad_data_out    (pad_data_out),
        .bit_cnt_out     (bit_cnt_out),
        .frame_out       (frame_out),
        .turbo_phase_out (turbo_phase_out)
    );

    always #20 clk_in = ~clk_in;

    typedef struct {
        logic       data;
        logic [3:0] cnt;
        logic       phase;
        string      tag;
    } exp_t;

    exp_t frame_q[$];
    exp_t shift_q[$];
    exp_t probe_q[$];

    int errors = 0;
    int checks = 0;
    int probe_issued = 0;

    // Reference model state: completed latch falls since reset, shifts
    // since the last load, and the word captured at the last load.
    int         falls = 0;
    int         shifts = 0;
    logic [7:0] loaded = 8'h00;

    function automatic logic phase_now();
        return ((falls / TF) % 2) == 1;
    endfunction

    function automatic logic [7:0] eff_model(input logic [7:0] b, input logic [1:0] t,
                                             input logic ph);
        logic [7:0] r;
        r = b;
        if (t[0] && !ph) r[0] = 1'b0;
        if (t[1] && !ph) r[1] = 1'b0;
        return r;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic cmp(input exp_t e);
        check({e.tag, "_data"},  {7'd0, pad_data_out},    {7'd0, e.data});
        check({e.tag, "_cnt"},   {4'd0, bit_cnt_out},     {4'd0, e.cnt});
        check({e.tag, "_phase"}, {7'd0, turbo_phase_out}, {7'd0, e.phase});
    endtask

    // Monitor
    initial begin
        logic [3:0] prev_cnt;
        logic       prev_frame;
        int         probe_seen;
        exp_t       e;
        prev_cnt   = 4'd0;
        prev_frame = 1'b0;
        probe_seen = 0;
        forever begin
            @(negedge clk_in);
            if (prev_frame === 1'b1) check("frame_width", {7'd0, frame_out}, 8'd0);
            if (frame_out === 1'b1 && prev_frame !== 1'b1) begin
                if (frame_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_frame: got pulse want none");
                end else begin
                    e = frame_q.pop_front();
                    cmp(e);
                end
            end
            if (bit_cnt_out > prev_cnt) begin
                if (shift_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_shift: got cnt %0d want no change", bit_cnt_out);
                end else begin
                    e = shift_q.pop_front();
                    cmp(e);
                end
            end
            if (probe_issued > probe_seen) begin
                probe_seen++;
                e = probe_q.pop_front();
                cmp(e);
            end
            prev_cnt   = bit_cnt_out;
            prev_frame = frame_out;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_in);
        #5;
    endtask

    task automatic push_probe(input string tag, input logic d, input logic [3:0] c);
        exp_t e;
        e.data  = d;
        e.cnt   = c;
        e.phase = phase_now();
        e.tag   = tag;
        probe_q.push_back(e);
        probe_issued++;
        cyc(1);
    endtask

    task automatic latch_end();
        exp_t e;
        pad_latch_in = 1'b0;
        loaded  = eff_model(buttons_in, turbo_en_in, phase_now());
        shifts  = 0;
        e.data  = ~loaded[0];
        e.cnt   = 4'd0;
        e.phase = phase_now();
        e.tag   = "frame";
        frame_q.push_back(e);
        falls++;
        cyc(SS + 4);
    endtask

    task automatic frame_latch(input int high_cycles);
        pad_latch_in = 1'b1;
        cyc(high_cycles);
        latch_end();
    endtask

    task automatic shift_clk();
        exp_t       e;
        logic [2:0] idx;
        pad_clk_in = 1'b1;
        shifts++;
        idx     = 3'(shifts);
        e.data  = (shifts >= 8) ? 1'b0 : ~loaded[idx];
        e.cnt   = (shifts >= 8) ? 4'd8 : 4'(shifts);
        e.phase = phase_now();
        e.tag   = "shift";
        if (shifts <= 8) shift_q.push_back(e);
        cyc(SS + 3);
        if (shifts > 8) push_probe("sat", e.data, e.cnt);
        pad_clk_in = 1'b0;
        cyc(SS + 3);
    endtask

    // Stimulus
    initial begin
        cyc(3);
        rst_in = 1'b0;
        push_probe("reset", 1'b1, 4'd0);
        cyc(2);

        // A+Start, 8 shifts then 4 extra
        buttons_in = 8'b0000_1001;
        frame_latch(4);
        repeat (12) shift_clk();

        // Latch held high: output tracks ~A, clocks ignored
        buttons_in   = 8'h00;
        pad_latch_in = 1'b1;
        cyc(SS + 4);
        push_probe("hold_rel", 1'b1, 4'd0);
        buttons_in[0] = 1'b1;
        cyc(4);
        push_probe("hold_a", 1'b0, 4'd0);
        repeat (2) begin
            pad_clk_in = 1'b1; cyc(6);
            pad_clk_in = 1'b0; cyc(6);
        end
        push_probe("hold_clk", 1'b0, 4'd0);
        buttons_in[0] = 1'b0;
        cyc(4);
        push_probe("hold_a_rel", 1'b1, 4'd0);
        buttons_in = 8'b1000_0010;
        latch_end();
        repeat (8) shift_clk();

        // Latch and shift clock rise together for a single cycle
        buttons_in   = 8'b0101_0001;
        pad_clk_in   = 1'b1;
        pad_latch_in = 1'b1;
        cyc(1);
        latch_end();
        pad_clk_in = 1'b0;
        cyc(SS + 3);
        repeat (8) shift_clk();

        // One more frame so the turbo phase is 1 before the reset
        buttons_in = 8'hA5;
        frame_latch(3);

        // Reset mid-transfer
        buttons_in = 8'h3C;
        frame_latch(3);
        repeat (3) shift_clk();
        rst_in = 1'b1;
        cyc(1);
        rst_in = 1'b0;
        falls  = 0;
        push_probe("rst_mid", 1'b1, 4'd0);
        cyc(3);

        // Turbo on A, 16 frames; first frame read out fully
        turbo_en_in = 2'b01;
        buttons_in  = 8'h01;
        frame_latch(4);
        repeat (8) shift_clk();
        repeat (15) begin
            frame_latch(4);
            cyc(4);
        end

        // Randomized frames with mid-shift button changes
        repeat (10) begin
            buttons_in  = 8'($urandom);
            turbo_en_in = 2'($urandom);
            frame_latch(1 + $urandom_range(0, 5));
            repeat (2) shift_clk();
            buttons_in = 8'($urandom);
            repeat (6 + $urandom_range(0, 3)) shift_clk();
        end

        cyc(20);
        check("frame_q_empty", 8'(frame_q.size()), 8'd0);
        check("shift_q_empty", 8'(shift_q.size()), 8'd0);
        check("probe_q_empty", 8'(probe_q.size()), 8'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
